dot_mac_pipe: RTL and testbench

- Parametrised, fully pipelined dot-product multiply-accumulate engine.
- Each accepted beat multiplies LANES operand pairs, reduces the products through a registered adder tree, and accumulates the sum into a group accumulator.
- Adds signed/unsigned mode, group framing (first/last), saturation and overflow reporting, and valid tracking through the pipeline.
- Sits between the operand fetch/buffer logic and the activation/writeback stage of the accelerator datapath.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/adder_tree_pipe.sv | 71 +++++++
 rtl/dot_mac_pipe.sv | 130 +++++++++++++
 tb/tb_dot_mac_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the dot-product MAC pipeline.
// Widths are functions because they depend on the instantiating module's parameters.
package mac_pkg;

    // Control flags that travel alongside each beat through the pipeline.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic mode;
    } side_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (longint unsigned w = 1; w < longint'(n); w = w << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned prod_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    function automatic int unsigned tree_width(input int unsigned dw, input int unsigned lanes);
        return 2 * dw + clog2(lanes);
    endfunction

    function automatic int unsigned padded_lanes(input int unsigned lanes);
        return 32'd1 << clog2(lanes);
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered binary adder tree: one register level per tree level, each level one bit wider.
// Operand extension per level follows the sign mode carried in the sideband.
module adder_tree_pipe
    import mac_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = 16,
    localparam int unsigned L  = clog2(N),
    localparam int unsigned OW = IW + L
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*IW-1:0] data_in,
    input  side_t           side_in,
    output logic [OW-1:0]   sum_out,
    output side_t           side_out
);

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int unsigned CNT = N >> l;
        localparam int unsigned W   = IW + l;

        logic [CNT*W-1:0] node;
        side_t            side;

        if (l == 0) begin : g_leaf
            assign node = data_in;
            assign side = side_in;
        end else begin : g_add
            localparam int unsigned PWD = W - 1;

            logic [2*CNT*PWD-1:0] prev;
            side_t                prev_side;
            logic [CNT*W-1:0]     node_d;
            logic [PWD-1:0]       lo;
            logic [PWD-1:0]       hi;

            assign prev      = g_lvl[l-1].node;
            assign prev_side = g_lvl[l-1].side;

            always_comb begin
                node_d = '0;
                lo     = '0;
                hi     = '0;
                for (int i = 0; i < int'(CNT); i++) begin
                    lo = prev[2*i*PWD +: PWD];
                    hi = prev[(2*i+1)*PWD +: PWD];
                    node_d[i*W +: W] = {prev_side.mode & lo[PWD-1], lo}
                                     + {prev_side.mode & hi[PWD-1], hi};
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    node <= '0;
                    side <= '0;
                end else begin
                    side <= prev_side;
                    // Data only moves with a valid slot; bubbles leave it parked.
                    if (prev_side.valid) begin
                        node <= node_d;
                    end
                end
            end
        end
    end

    assign sum_out  = g_lvl[L].node;
    assign side_out = g_lvl[L].side;

endmodule

// File: rtl/dot_mac_pipe.sv
// Pipelined dot-product MAC: product stage, registered adder tree, group accumulator
// with first/last framing, signed/unsigned beats, and optional saturation.
module dot_mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned ACCW  = 28,
    parameter int unsigned SAT   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES*DW-1:0] a_in,
    input  logic [LANES*DW-1:0] b_in,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic                in_last,
    input  logic                signed_mode,
    output logic [ACCW-1:0]     acc_out,
    output logic                out_valid,
    output logic                ovf
);

    localparam int unsigned LP = padded_lanes(LANES);
    localparam int unsigned PW = prod_width(DW);
    localparam int unsigned TW = tree_width(DW, LANES);

    if (ACCW < TW) begin : g_accw_check
        $error("dot_mac_pipe: ACCW must be at least 2*DW + clog2(LANES)");
    end

    logic [LP*PW-1:0] prod_d;
    logic [LP*PW-1:0] prod_q;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    side_t            side_d;
    side_t            side_p;
    side_t            side_s;
    logic [TW-1:0]    tree_sum;

    assign side_d = {in_valid, in_valid & in_first, in_valid & in_last, signed_mode};

    // Extending both operands to PW bits makes the PW-bit product correct for either mode.
    always_comb begin
        prod_d = '0;
        a_ext  = '0;
        b_ext  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            a_ext = {{DW{signed_mode & a_in[i*DW + DW - 1]}}, a_in[i*DW +: DW]};
            b_ext = {{DW{signed_mode & b_in[i*DW + DW - 1]}}, b_in[i*DW +: DW]};
            prod_d[i*PW +: PW] = a_ext * b_ext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            side_p <= '0;
        end else begin
            side_p <= side_d;
            if (in_valid) begin
                prod_q <= prod_d;
            end
        end
    end

    adder_tree_pipe #(
        .N  (LP),
        .IW (PW)
    ) u_tree (
        .clk      (clk),
        .reset    (reset),
        .data_in  (prod_q),
        .side_in  (side_p),
        .sum_out  (tree_sum),
        .side_out (side_s)
    );

    logic [ACCW-1:0] sum_ext;
    logic [ACCW-1:0] base;
    logic [ACCW:0]   total;
    logic [ACCW-1:0] acc_d;
    logic [ACCW-1:0] acc_q;
    logic            ovf_now;
    logic            ovf_d;
    logic            ovf_q;
    logic            out_valid_q;

    always_comb begin
        sum_ext = side_s.mode ? ACCW'($signed(tree_sum)) : ACCW'(tree_sum);
        base    = side_s.first ? '0 : acc_q;
        if (side_s.mode) begin
            total = {base[ACCW-1], base} + {sum_ext[ACCW-1], sum_ext};
        end else begin
            total = {1'b0, base} + {1'b0, sum_ext};
        end
        ovf_now = side_s.mode ? (total[ACCW] ^ total[ACCW-1]) : total[ACCW];
        acc_d   = total[ACCW-1:0];
        if (SAT != 0 && ovf_now) begin
            if (!side_s.mode) begin
                acc_d = '1;
            end else if (total[ACCW]) begin
                acc_d = {1'b1, {(ACCW-1){1'b0}}};
            end else begin
                acc_d = {1'b0, {(ACCW-1){1'b1}}};
            end
        end
        // A first beat restarts the group's sticky overflow.
        ovf_d = (ovf_q & ~side_s.first) | ovf_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= side_s.valid & side_s.last;
            if (side_s.valid) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_mac_pipe.sv
// Bench for dot_mac_pipe: four parameterisations share one stimulus stream and are each
// compared against an arithmetic group-accumulator model delayed by the pipeline latency.
module tb_dot_mac_pipe;

    localparam int NI  = 4;
    localparam int LAT = 6;

    int lanes_c [NI] = '{16, 16, 16, 12};
    int accw_c  [NI] = '{28, 20, 20, 28};
    int sat_c   [NI] = '{0, 1, 0, 0};

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [127:0]   a_in = '0;
    logic [127:0]   b_in = '0;
    logic           in_valid = 1'b0;
    logic           in_first = 1'b0;
    logic           in_last = 1'b0;
    logic           signed_mode = 1'b0;
    logic [27:0]    acc0;
    logic [19:0]    acc1;
    logic [19:0]    acc2;
    logic [27:0]    acc3;
    logic [NI-1:0]  ov_o;
    logic [NI-1:0]  ovf_o;

    always #5 clk = ~clk;

    dot_mac_pipe #(.LANES(16), .DW(8), .ACCW(28), .SAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
        .acc_out(acc0), .out_valid(ov_o[0]), .ovf(ovf_o[0]));

    dot_mac_pipe #(.LANES(16), .DW(8), .ACCW(20), .SAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
        .acc_out(acc1), .out_valid(ov_o[1]), .ovf(ovf_o[1]));

    dot_mac_pipe #(.LANES(16), .DW(8), .ACCW(20), .SAT(0)) u_dut2 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
        .acc_out(acc2), .out_valid(ov_o[2]), .ovf(ovf_o[2]));

    dot_mac_pipe #(.LANES(12), .DW(8), .ACCW(28), .SAT(0)) u_dut3 (
        .clk(clk), .reset(reset), .a_in(a_in[95:0]), .b_in(b_in[95:0]), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .signed_mode(signed_mode),
        .acc_out(acc3), .out_valid(ov_o[3]), .ovf(ovf_o[3]));

    typedef struct {
        longint acc;
        bit     ovf;
        bit     ov;
    } exp_t;

    exp_t   exp_q [NI][$];
    longint m_acc [NI];
    bit     m_ovf [NI];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint observed_acc(input int i);
        case (i)
            0:       return longint'(acc0);
            1:       return longint'(acc1);
            2:       return longint'(acc2);
            default: return longint'(acc3);
        endcase
    endfunction

    function automatic logic [127:0] splat(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic longint lane_sum(input int n, input bit m);
        longint     s;
        logic [7:0] ab;
        logic [7:0] bb;
        longint     sa;
        longint     sb;
        s = 0;
        for (int k = 0; k < n; k++) begin
            ab = a_in[k*8 +: 8];
            bb = b_in[k*8 +: 8];
            sa = m ? longint'($signed(ab)) : longint'(ab);
            sb = m ? longint'($signed(bb)) : longint'(bb);
            s += sa * sb;
        end
        return s;
    endfunction

    task automatic model_reset();
        exp_t e;
        e.acc = 0;
        e.ovf = 1'b0;
        e.ov  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
            exp_q[i].delete();
            repeat (LAT - 1) exp_q[i].push_back(e);
        end
    endtask

    // Group accumulator in plain integer arithmetic, one update per sampled beat.
    task automatic model_beat();
        exp_t   e;
        longint s, base, bs, t, r, md, half;
        bit     o;
        for (int i = 0; i < NI; i++) begin
            e.ov = 1'b0;
            if (in_valid) begin
                s    = lane_sum(lanes_c[i], signed_mode);
                md   = longint'(1) << accw_c[i];
                half = md / 2;
                base = in_first ? 0 : m_acc[i];
                if (signed_mode) begin
                    bs = (base >= half) ? base - md : base;
                    t  = bs + s;
                    o  = (t >= half) || (t < -half);
                    if (o && sat_c[i] != 0) r = (t < 0) ? half : half - 1;
                    else r = ((t % md) + md) % md;
                end else begin
                    t = base + s;
                    o = (t >= md);
                    r = (o && sat_c[i] != 0) ? md - 1 : t % md;
                end
                m_acc[i] = r;
                m_ovf[i] = (in_first ? 1'b0 : m_ovf[i]) | o;
                e.ov     = in_last;
            end
            e.acc = m_acc[i];
            e.ovf = m_ovf[i];
            exp_q[i].push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_beat();
        #1;
        for (int i = 0; i < NI; i++) begin
            e = exp_q[i].pop_front();
            check($sformatf("dut%0d acc", i), observed_acc(i), e.acc);
            check($sformatf("dut%0d out_valid", i), longint'(ov_o[i]), longint'(e.ov));
            if (e.ov) check($sformatf("dut%0d ovf", i), longint'(ovf_o[i]), longint'(e.ovf));
        end
    endtask

    task automatic issue(input logic [127:0] a, input logic [127:0] b,
                         input bit v, input bit f, input bit l, input bit m);
        a_in        = a;
        b_in        = b;
        in_valid    = v;
        in_first    = f;
        in_last     = l;
        signed_mode = m;
        step();
    endtask

    // Bubbles carry junk framing and data to show it is ignored without in_valid.
    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) begin
            issue({$urandom(), $urandom(), $urandom(), $urandom()},
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    logic [127:0] ramp;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset acc%0d", i), observed_acc(i), 0);
            check($sformatf("reset out_valid%0d", i), longint'(ov_o[i]), 0);
            check($sformatf("reset ovf%0d", i), longint'(ovf_o[i]), 0);
        end
        reset = 1'b1;

        // Unsigned maximum, single-beat group.
        issue(splat(8'hFF), splat(8'hFF), 1'b1, 1'b1, 1'b1, 1'b0);
        bubbles(4);
        check("umax early pulse", longint'(ov_o[0]), 0);
        bubbles(1);
        check("umax acc", longint'(acc0), 1040400);
        check("umax pulse", longint'(ov_o[0]), 1);
        check("umax ovf", longint'(ovf_o[0]), 0);
        check("umax lanes12 acc", longint'(acc3), 780300);
        bubbles(1);
        check("umax pulse end", longint'(ov_o[0]), 0);

        // Signed extreme.
        issue(splat(8'h80), splat(8'h7F), 1'b1, 1'b1, 1'b1, 1'b1);
        bubbles(5);
        check("sext acc", longint'(acc0), longint'(28'hFFC0800));
        check("sext ovf", longint'(ovf_o[0]), 0);

        // Three-beat group, back to back and then with 2-cycle bubbles.
        for (int k = 0; k < 16; k++) ramp[k*8 +: 8] = 8'(k);
        issue(splat(8'd1), ramp, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(splat(8'd1), ramp, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(splat(8'd1), ramp, 1'b1, 1'b0, 1'b1, 1'b0);
        bubbles(5);
        check("group acc", longint'(acc0), 360);
        check("group pulse", longint'(ov_o[0]), 1);
        issue(splat(8'd1), ramp, 1'b1, 1'b1, 1'b0, 1'b0);
        bubbles(2);
        issue(splat(8'd1), ramp, 1'b1, 1'b0, 1'b0, 1'b0);
        bubbles(2);
        issue(splat(8'd1), ramp, 1'b1, 1'b0, 1'b1, 1'b0);
        bubbles(5);
        check("gapped acc", longint'(acc0), 360);
        check("gapped pulse", longint'(ov_o[0]), 1);

        // Unsigned overflow on the 20-bit accumulators.
        issue(splat(8'hFF), splat(8'hFF), 1'b1, 1'b1, 1'b0, 1'b0);
        issue(splat(8'hFF), splat(8'hFF), 1'b1, 1'b0, 1'b1, 1'b0);
        bubbles(5);
        check("sat acc", longint'(acc1), 1048575);
        check("sat ovf", longint'(ovf_o[1]), 1);
        check("wrap acc", longint'(acc2), 1032224);
        check("wrap ovf", longint'(ovf_o[2]), 1);
        check("wide acc", longint'(acc0), 2080800);
        issue(splat(8'd1), splat(8'd1), 1'b1, 1'b1, 1'b1, 1'b0);
        bubbles(5);
        check("sat next ovf", longint'(ovf_o[1]), 0);
        check("wrap next ovf", longint'(ovf_o[2]), 0);
        check("sat next acc", longint'(acc1), 16);

        // Reset in the middle of a group.
        issue(splat(8'd5), splat(8'd7), 1'b1, 1'b1, 1'b0, 1'b0);
        issue(splat(8'd5), splat(8'd7), 1'b1, 1'b0, 1'b0, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midrst acc%0d", i), observed_acc(i), 0);
            check($sformatf("midrst out_valid%0d", i), longint'(ov_o[i]), 0);
        end
        @(posedge clk);
        #1;
        check("midrst held acc", longint'(acc0), 0);
        reset = 1'b1;
        model_reset();
        bubbles(LAT);
        issue(splat(8'd2), splat(8'd3), 1'b1, 1'b1, 1'b1, 1'b0);
        bubbles(5);
        check("post reset acc", longint'(acc0), 96);
        check("post reset pulse", longint'(ov_o[0]), 1);

        // Adjacent single-beat groups through the padded 12-lane instance.
        issue(splat(8'd1), splat(8'd1), 1'b1, 1'b1, 1'b1, 1'b0);
        issue(splat(8'd2), splat(8'd3), 1'b1, 1'b1, 1'b1, 1'b0);
        bubbles(4);
        check("adj A acc", longint'(acc3), 12);
        check("adj A pulse", longint'(ov_o[3]), 1);
        bubbles(1);
        check("adj B acc", longint'(acc3), 72);
        check("adj B pulse", longint'(ov_o[3]), 1);
        bubbles(1);
        check("adj pulse end", longint'(ov_o[3]), 0);

        // Random beats, framing and modes.
        for (int n = 0; n < 400; n++) begin
            issue({$urandom(), $urandom(), $urandom(), $urandom()},
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  $urandom_range(3) != 0, $urandom_range(3) == 0,
                  $urandom_range(3) == 0, 1'($urandom_range(1)));
        end
        bubbles(LAT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
